// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit limit,
// buffers returned words for the decoder, and squashes everything on redirect.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   head_pc;
  logic [31:0]   target_pc;
  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW:0]   credit_sum;
  logic          misalign_q;
  logic          xfer;
  logic          push;
  logic          drop;
  logic          pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_nxt;

  assign target_pc    = redirect_pc;
  assign misalign_nxt = |redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect) begin
      misalign_q <= misalign_nxt;
    end
  end
`else
  logic unused_align_bits;

  // Low target bits are dropped: redirects always land on a word boundary.
  assign target_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_align_bits = ^redirect_pc[1:0];
  assign misalign_q        = 1'b0;
`endif

  // Credit covers both FIFO occupancy and in-flight words so a push can never overflow.
  assign credit_sum = {1'b0, outstanding} + {1'b0, count};
  assign imem_req   = !rst && !redirect && !misalign_q && (credit_sum < DEPTH_C);
  assign imem_addr  = pc;

  assign xfer       = imem_req && imem_gnt;
  assign drop       = imem_rvalid && (discard != '0);
  assign push       = imem_rvalid && (discard == '0) && !redirect;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;

  assign inst       = inst_valid ? fifo_mem[rd_ptr] : '0;
  assign inst_pc    = head_pc;
  assign misalign   = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(xfer) - CW'(imem_rvalid);
      if (redirect) begin
        pc      <= target_pc;
        head_pc <= target_pc;
        count   <= '0;
        rd_ptr  <= wr_ptr;
        // Everything still in flight after this edge belongs to the old stream.
        discard <= outstanding - CW'(imem_rvalid);
      end else begin
        if (xfer) begin
          pc <= pc + 32'd4;
        end
        if (pop) begin
          head_pc <= head_pc + 32'd4;
          rd_ptr  <= rd_ptr + PW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
        if (drop) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
